// File: rtl/shift_seq_ctrl_if.sv
// Command channel of the shift-register sequencer: one valid/ready handshake
// per load or clear command.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_clr;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_clr, cmd_dir, cmd_len, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_clr, cmd_dir, cmd_len, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer that serially loads or clears the bidirectional shift register
// by driving its d/en/dir/rstn pins, one command per handshake.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    shift_seq_ctrl_if.slave       cmd,
    input  logic                  stall,
    output logic                  sr_d,
    output logic                  sr_en,
    output logic                  sr_dir,
    output logic                  sr_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(WIDTH);

    typedef struct packed {
        logic             dir;
        logic [CNT_W-1:0] len;
        logic [WIDTH-1:0] data;
    } cmd_t;

    logic [1:0]       state;
    cmd_t             cq;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] bit_idx;
    logic [WIDTH-1:0] data_sh;
    logic             accept;
    logic             len_bad;
    logic             last_shift;

    // A zero length field stands for a full-width load.
    assign eff_len    = (cmd.cmd_len == '0) ? LEN_FULL : cmd.cmd_len;
    assign len_bad    = eff_len > LEN_FULL;
    assign accept     = cmd.cmd_valid && cmd.cmd_ready;
    assign last_shift = sr_en && (cnt == cq.len - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            cq    <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd.cmd_clr) begin
                            state <= S_CLEAR;
                        end else if (len_bad) begin
                            err <= 1'b1;
                        end else begin
                            cq    <= '{dir: cmd.cmd_dir, len: eff_len, data: cmd.cmd_data};
                            cnt   <= '0;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sr_en) cnt <= cnt + CNT_W'(1);
                    if (last_shift) state <= S_DONE;
                end
                S_CLEAR: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Left loads send the MSB of the field first so it lands at bit len-1;
    // right loads send the lowest bit of the top field first so it lands at
    // bit WIDTH-len.
    always_comb begin
        if (cq.dir) bit_idx = LEN_FULL - cq.len + cnt;
        else        bit_idx = cq.len - CNT_W'(1) - cnt;
        data_sh = cq.data >> bit_idx;
    end

    assign sr_en         = (state == S_SHIFT) && !stall;
    assign sr_d          = (state == S_SHIFT) && data_sh[0];
    assign sr_dir        = cq.dir;
    assign sr_rstn       = (state != S_CLEAR);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign cmd.cmd_ready = (state == S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: directed test-plan cases with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_shift_seq_ctrl;
    localparam int W  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic stall = 1'b0;
    logic sr_d, sr_en, sr_dir, sr_rstn, busy, done, err;

    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cmd    (cif),
        .stall  (stall),
        .sr_d   (sr_d),
        .sr_en  (sr_en),
        .sr_dir (sr_dir),
        .sr_rstn(sr_rstn),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: spec-level phase, queue of bits still to be sent.
    int         ph = 0;          // 0 idle, 1 shift, 2 clear, 3 done
    bit         mvalid = 0;
    bit         m_err = 0;
    bit         m_dir = 0;
    bit         q[$];
    logic [W-1:0] m_target = '0;
    logic [W-1:0] sreg = '0;     // the controlled shift register
    bit         cap[$];
    int         acc_cyc = 0, done_cyc = 0, done_cnt = 0, rst_lo_cnt = 0;
    logic [7:0] exp_o, got_o;

    always @(negedge clk) begin
        if (mvalid) begin
            exp_o = {ph == 0, ph != 0, ph == 3, m_err, (ph == 1) && !stall,
                     (ph == 1) ? q[0] : 1'b0, m_dir, ph != 2};
            got_o = {cif.cmd_ready, busy, done, err, sr_en, sr_d, sr_dir, sr_rstn};
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL outputs cyc=%0d rdy/busy/done/err/en/d/dir/rstn got=%b exp=%b",
                         cyc, got_o, exp_o);
            end
            if (ph == 3) begin
                checks++;
                if (sreg !== m_target) begin
                    errors++;
                    $display("FAIL register cyc=%0d got=%b exp=%b", cyc, sreg, m_target);
                end
            end
        end
        if (done) begin done_cyc = cyc; done_cnt++; end
        if (!sr_rstn) rst_lo_cnt++;
        if (sr_en) cap.push_back(sr_d);
        if (!sr_rstn)   sreg = '0;
        else if (sr_en) sreg = sr_dir ? {sr_d, sreg[W-1:1]} : {sreg[W-2:0], sr_d};

        if (!rstn) begin
            ph = 0; q.delete(); m_err = 0; m_dir = 0; mvalid = 1;
        end else begin
            m_err = 0;
            case (ph)
                0: if (cif.cmd_valid) begin
                    if (cif.cmd_clr) begin
                        ph = 2; m_target = '0;
                        acc_cyc = cyc; cap.delete(); rst_lo_cnt = 0;
                    end else begin
                        int eff, o, dd, full;
                        logic [W-1:0] d;
                        eff = (cif.cmd_len == 0) ? W : int'(cif.cmd_len);
                        if (eff > W) m_err = 1;
                        else begin
                            d = cif.cmd_data; dd = int'(d); o = int'(sreg);
                            full = (1 << W) - 1;
                            m_dir = cif.cmd_dir;
                            q.delete();
                            for (int k = 0; k < eff; k++)
                                q.push_back(m_dir ? d[W-eff+k] : d[eff-1-k]);
                            if (!m_dir) m_target = W'(((o << eff) | (dd & ((1 << eff) - 1))) & full);
                            else        m_target = W'((o >> eff) | (dd & (full ^ (full >> eff))));
                            ph = 1;
                            acc_cyc = cyc; cap.delete(); rst_lo_cnt = 0;
                        end
                    end
                end
                1: if (!stall) begin
                    void'(q.pop_front());
                    if (q.size() == 0) ph = 3;
                end
                2: ph = 3;
                default: ph = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic send(input bit clr, input bit dir, input int len, input int data);
        cif.cmd_valid = 1'b1;
        cif.cmd_clr   = clr;
        cif.cmd_dir   = dir;
        cif.cmd_len   = CW'(len);
        cif.cmd_data  = W'(data);
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cif.cmd_ready && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL idle_timeout got=busy exp=idle within 100 cycles");
        end
    endtask

    function automatic int capval();
        int v = 0;
        foreach (cap[i]) v = (v << 1) | int'(cap[i]);
        return v;
    endfunction

    initial begin
        int d0;
        cif.cmd_valid = 0; cif.cmd_clr = 0; cif.cmd_dir = 0;
        cif.cmd_len = '0; cif.cmd_data = '0;
        tick(); tick();
        rstn = 1'b1;
        chk("reset_ready", int'(cif.cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rstn_pin", int'(sr_rstn), 1);

        // full-width left load
        send(0, 0, 0, 4'b1011); wait_idle();
        chk("l4_done_lat", done_cyc - acc_cyc, 5);
        chk("l4_bits", capval(), 4'b1011);
        chk("l4_reg", int'(sreg), 4'b1011);

        // fill with ones, then clear
        send(0, 0, 4, 4'b1111); wait_idle();
        chk("fill_reg", int'(sreg), 4'b1111);
        send(1, 0, 0, 0); wait_idle();
        chk("clr_done_lat", done_cyc - acc_cyc, 2);
        chk("clr_rstn_cycles", rst_lo_cnt, 1);
        chk("clr_reg", int'(sreg), 0);

        // 2-bit right load into empty register
        send(0, 1, 2, 4'b1000); wait_idle();
        chk("r2_done_lat", done_cyc - acc_cyc, 3);
        chk("r2_nbits", cap.size(), 2);
        chk("r2_bits", capval(), 2'b01);
        chk("r2_reg", int'(sreg), 4'b1000);

        // left load with a 3-cycle stall after the 2nd shift
        send(0, 0, 4, 4'b0110);
        tick(); tick();
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0;
        wait_idle();
        chk("stall_done_lat", done_cyc - acc_cyc, 8);
        chk("stall_bits", capval(), 4'b0110);
        chk("stall_reg", int'(sreg), 4'b0110);

        // over-length command is rejected
        send(0, 0, 5, 4'b1111);
        chk("bad_err", int'(err), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_ready", int'(cif.cmd_ready), 1);
        tick();
        chk("bad_err_clear", int'(err), 0);

        // reset during the 2nd shift aborts without done
        d0 = done_cnt;
        send(0, 0, 4, 4'b1111);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_en", int'(sr_en), 0);
        chk("abort_ready", int'(cif.cmd_ready), 1);
        send(0, 1, 0, 4'b0101); wait_idle();
        chk("abort_done_count", done_cnt - d0, 1);
        chk("after_abort_lat", done_cyc - acc_cyc, 5);
        chk("after_abort_reg", int'(sreg), 4'b0101);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cif.cmd_valid = ($urandom_range(0, 2) != 0);
            cif.cmd_clr   = ($urandom_range(0, 7) == 0);
            cif.cmd_dir   = 1'($urandom);
            cif.cmd_len   = CW'($urandom_range(0, 7));
            cif.cmd_data  = W'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            rstn          = ($urandom_range(0, 199) != 0);
            tick();
        end
        cif.cmd_valid = 0; stall = 0; rstn = 1;
        tick();
        wait_idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
